// File: rtl/rc5_sched_pkg.sv
// Shared types and helpers for the RC5 engine scheduler: FSM states, mode encoding
// and the tag-width calculation.
package rc5_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Bits needed to index n items, never less than one.
    function automatic int calc_id_w(input int n);
        calc_id_w = (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rc5_engine_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or above ptr, wrapping
// around, and reports the winner both one-hot and encoded.
module rr_arbiter
    import rc5_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = calc_id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    int              cand_s;
    logic [ID_W-1:0] cidx_s;
    logic            hit_s;
    logic            found_s;

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        cand_s  = 0;
        cidx_s  = '0;
        hit_s   = 1'b0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s  = int'(ptr) + i;
            cand_s  = (cand_s >= NUM_REQ) ? (cand_s - NUM_REQ) : cand_s;
            cidx_s  = ID_W'(cand_s);
            hit_s   = enable & ~found_s & req[cidx_s];
            grant[cidx_s] = grant[cidx_s] | hit_s;
            idx     = hit_s ? cidx_s : idx;
            found_s = found_s | hit_s;
        end
    end

endmodule

// File: rtl/rc5_engine_sched.sv
// Shares one RC5 encrypt core and one RC5 decrypt core among NUM_REQ requesters:
// round-robin grant, hold the core input for LATENCY cycles, return a tagged result.
module rc5_engine_sched
    import rc5_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 61,
    parameter int ID_W    = calc_id_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_mode,
    output logic [DATA_W-1:0]         eng_din,
    input  logic [DATA_W-1:0]         eng_dout_enc,
    input  logic [DATA_W-1:0]         eng_dout_dec,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_mode,
    output logic                      busy
);

    localparam int CNT_W = calc_id_w(LATENCY);

    sched_state_t       state_r;
    logic [ID_W-1:0]    ptr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               mode_r;
    logic [ID_W-1:0]    id_r;

    logic               arb_en_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]    gidx_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic               sel_mode_s;
    logic [ID_W-1:0]    ptr_next_s;

    // Grants only while idle and never during reset.
    assign arb_en_s  = (state_r == IDLE) & ~rst;
    assign req_ready = grant_s;
    assign busy      = (state_r != IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_r),
        .enable (arb_en_s),
        .grant  (grant_s),
        .idx    (gidx_s)
    );

    // Mux out the winner's block and mode, plus the pointer that follows it.
    always_comb begin
        sel_data_s = '0;
        sel_mode_s = MODE_ENC;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data_s = (gidx_s == ID_W'(i)) ? req_data[i*DATA_W +: DATA_W] : sel_data_s;
            sel_mode_s = (gidx_s == ID_W'(i)) ? req_mode[i] : sel_mode_s;
        end
        if (gidx_s == ID_W'(NUM_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = gidx_s + ID_W'(1);
        end
    end

    // Scheduler FSM: grant, hold the core input for LATENCY cycles, present the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            cnt_r     <= '0;
            mode_r    <= MODE_ENC;
            id_r      <= '0;
            eng_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_mode  <= MODE_ENC;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|grant_s) begin
                        eng_din <= sel_data_s;
                        mode_r  <= sel_mode_s;
                        id_r    <= gidx_s;
                        cnt_r   <= CNT_W'(LATENCY - 1);
                        ptr_r   <= ptr_next_s;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        rsp_data  <= (mode_r == MODE_DEC) ? eng_dout_dec : eng_dout_enc;
                        rsp_id    <= id_r;
                        rsp_mode  <= mode_r;
                        rsp_valid <= 1'b1;
                        state_r   <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_engine_sched.sv
// Self-checking bench for rc5_engine_sched: fixed-latency core models (XOR stubs or a
// behavioural RC5-32/12/16), directed scenarios and a randomized scoreboard phase.
module tb_rc5_engine_sched;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 64;
    localparam int LAT     = 61;
    localparam int ID_W    = 1;
    localparam logic [63:0] ENC_K = 64'hA5A5A5A5A5A5A5A5;
    localparam logic [63:0] DEC_K = 64'h5A5A5A5A5A5A5A5A;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_mode;
    logic [DATA_W-1:0]         eng_din;
    logic [DATA_W-1:0]         eng_dout_enc;
    logic [DATA_W-1:0]         eng_dout_dec;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_mode;
    logic                      busy;

    int n_chk  = 0;
    int n_fail = 0;
    logic use_rc5 = 1'b0;

    always #5 clk = ~clk;

    rc5_engine_sched #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .LATENCY (LAT),
        .ID_W    (ID_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .req_mode     (req_mode),
        .eng_din      (eng_din),
        .eng_dout_enc (eng_dout_enc),
        .eng_dout_dec (eng_dout_dec),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_id       (rsp_id),
        .rsp_mode     (rsp_mode),
        .busy         (busy)
    );

    // ---------------- behavioural RC5-32/12/16 ----------------
    logic [31:0] s_tab [0:25];

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [31:0] n);
        logic [5:0] s;
        s = {1'b0, n[4:0]};
        return (x << s) | (x >> (6'd32 - s));
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [31:0] n);
        logic [5:0] s;
        s = {1'b0, n[4:0]};
        return (x >> s) | (x << (6'd32 - s));
    endfunction

    function automatic logic [63:0] rc5_enc(input logic [63:0] d);
        logic [31:0] a, b;
        a = d[31:0] + s_tab[0];
        b = d[63:32] + s_tab[1];
        for (int i = 1; i <= 12; i++) begin
            a = rotl(a ^ b, b) + s_tab[2*i];
            b = rotl(b ^ a, a) + s_tab[2*i+1];
        end
        return {b, a};
    endfunction

    function automatic logic [63:0] rc5_dec(input logic [63:0] d);
        logic [31:0] a, b;
        a = d[31:0];
        b = d[63:32];
        for (int i = 12; i >= 1; i--) begin
            b = rotr(b - s_tab[2*i+1], a) ^ a;
            a = rotr(a - s_tab[2*i], b) ^ b;
        end
        return {b - s_tab[1], a - s_tab[0]};
    endfunction

    task automatic key_schedule();
        logic [31:0] l_w [0:3];
        logic [31:0] a, b;
        int i, j;
        l_w[0] = 32'h03020100; l_w[1] = 32'h07060504;
        l_w[2] = 32'h0B0A0908; l_w[3] = 32'h0F0E0D0C;
        s_tab[0] = 32'hB7E15163;
        for (int k = 1; k < 26; k++) s_tab[k] = s_tab[k-1] + 32'h9E3779B9;
        a = 32'd0; b = 32'd0; i = 0; j = 0;
        for (int k = 0; k < 78; k++) begin
            s_tab[i] = rotl(s_tab[i] + a + b, 32'd3);
            a = s_tab[i];
            l_w[j] = rotl(l_w[j] + a + b, a + b);
            b = l_w[j];
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
    endtask

    // Core models: the result for eng_din is available LAT edges after it is driven.
    logic [63:0] enc_pipe [0:LAT-2];
    logic [63:0] dec_pipe [0:LAT-2];
    always @(posedge clk) begin
        enc_pipe[0] <= use_rc5 ? rc5_enc(eng_din) : (eng_din ^ ENC_K);
        dec_pipe[0] <= use_rc5 ? rc5_dec(eng_din) : (eng_din ^ DEC_K);
        for (int i = 1; i < LAT - 1; i++) begin
            enc_pipe[i] <= enc_pipe[i-1];
            dec_pipe[i] <= dec_pipe[i-1];
        end
    end
    assign eng_dout_enc = enc_pipe[LAT-2];
    assign eng_dout_dec = dec_pipe[LAT-2];

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Present one request, check the grant, then scramble the requester's inputs.
    task automatic issue(input int r, input logic [63:0] d, input logic m);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[r] = 1'b1;
        req_valid[r] = 1'b1;
        req_data[r*DATA_W +: DATA_W] = d;
        req_mode[r] = m;
        #1;
        chk("grant", req_ready, oh);
        step();
        req_valid[r] = 1'b0;
        req_data[r*DATA_W +: DATA_W] = ~d;
        req_mode[r] = ~m;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 200) begin
            step();
            cyc++;
        end
        chk("rsp_seen", rsp_valid, 1'b1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("consumed", rsp_valid, 1'b0);
        chk("idle_after", busy, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, req_ready, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_eng_din"}, eng_din, '0);
        chk({tag, "_rsp_data"}, rsp_data, '0);
        chk({tag, "_rsp_id"}, rsp_id, '0);
        chk({tag, "_rsp_mode"}, rsp_mode, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c;
        int          hi_cnt;
        logic [63:0] d, ct;

        key_schedule();
        rst       = 1'b1;
        req_valid = 2'b11;
        req_data  = {$urandom, $urandom, $urandom, $urandom};
        req_mode  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst       = 1'b0;
        req_valid = '0;
        step();

        // Single encrypt: latency, data, tag; inputs held afterwards.
        issue(0, 64'h0123456789ABCDEF, 1'b0);
        chk("hold_busy", busy, 1'b1);
        chk("hold_ready", req_ready, 2'b00);
        wait_rsp(c);
        chk("enc_latency", c, LAT);
        chk("enc_data", rsp_data, 64'hA486E0C22C0E684A);
        chk("enc_id", rsp_id, 1'b0);
        chk("enc_mode", rsp_mode, 1'b0);
        chk("enc_din_held", eng_din, 64'h0123456789ABCDEF);
        consume();
        chk("data_kept", rsp_data, 64'hA486E0C22C0E684A);

        // Mode select on the same kind of stub.
        issue(0, 64'hFFFF0000FFFF0000, 1'b1);
        wait_rsp(c);
        chk("dec_data", rsp_data, 64'hA5A55A5AA5A55A5A);
        chk("dec_mode", rsp_mode, 1'b1);
        consume();

        // Contention from pointer 0: strict alternation, back-to-back rate.
        do_reset();
        req_data  = {64'h2, 64'h1};
        req_mode  = 2'b00;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_rsp(c);
            chk("rr_gap", c, LAT + 1);
            chk("rr_id", rsp_id, k % 2);
            chk("rr_data", rsp_data, 64'(k % 2 + 1) ^ ENC_K);
            step();
            chk("rr_consumed", rsp_valid, 1'b0);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        step();

        // Backpressure: response frozen, no grants, then exactly one consume.
        d = {$urandom, $urandom};
        issue(1, d, 1'b0);
        wait_rsp(c);
        req_valid[0] = 1'b1;
        req_data[DATA_W-1:0] = {$urandom, $urandom};
        for (int k = 0; k < 20; k++) begin
            step();
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_data", rsp_data, d ^ ENC_K);
            chk("bp_id", rsp_id, 1'b1);
            chk("bp_mode", rsp_mode, 1'b0);
            chk("bp_ready", req_ready, 2'b00);
            chk("bp_busy", busy, 1'b1);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_released", rsp_valid, 1'b0);
        chk("bp_idle", busy, 1'b0);
        chk("bp_regrant", req_ready, 2'b01);
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        chk("bp_no_repeat", rsp_valid, 1'b0);
        chk("bp_no_grant", busy, 1'b0);

        // Round trip through the RC5 core models.
        use_rc5 = 1'b1;
        d  = 64'h0123456789ABCDEF;
        ct = rc5_enc(d);
        issue(0, d, 1'b0);
        wait_rsp(c);
        chk("rt_cipher", rsp_data, ct);
        consume();
        issue(1, ct, 1'b1);
        wait_rsp(c);
        chk("rt_plain", rsp_data, d);
        chk("rt_id", rsp_id, 1'b1);
        chk("rt_mode", rsp_mode, 1'b1);
        consume();
        use_rc5 = 1'b0;

        // Reset in the middle of WAIT discards the block.
        issue(1, 64'h1122334455667788, 1'b0);
        repeat (29) step();
        rst = 1'b1;
        req_valid = 2'b01;
        #1;
        chk_reset_vals("midrst");
        step();
        rst = 1'b0;
        req_valid = '0;
        hi_cnt = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            hi_cnt += int'(rsp_valid);
        end
        chk("midrst_no_rsp", hi_cnt, 0);
        issue(0, 64'hCAFEF00D12345678, 1'b0);
        wait_rsp(c);
        chk("midrst_latency", c, LAT);
        chk("midrst_data", rsp_data, 64'hCAFEF00D12345678 ^ ENC_K);
        consume();

        // Randomized phase against a transaction-level scoreboard.
        do_reset();
        begin
            int                 ptr_m, gcyc, n_rsp, lastg, g;
            bit                 outst;
            logic [NUM_REQ-1:0] exp_rdy;
            logic [63:0]        e_din, e_data;
            logic               e_mode;
            logic [ID_W-1:0]    e_id;
            ptr_m = 0; gcyc = 0; n_rsp = 0; lastg = -1; outst = 1'b0;
            e_din = '0; e_data = '0; e_mode = 1'b0; e_id = '0;
            for (int cyc = 0; cyc < 5000 && n_rsp < 30; cyc++) begin
                @(negedge clk);
                if (lastg >= 0) begin
                    req_valid[lastg] = 1'b0;
                    lastg = -1;
                end
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (!req_valid[r] && $urandom_range(3) == 0) begin
                        req_valid[r] = 1'b1;
                        req_data[r*DATA_W +: DATA_W] = {$urandom, $urandom};
                        req_mode[r] = 1'($urandom_range(1));
                    end else if (req_valid[r] && $urandom_range(15) == 0) begin
                        req_valid[r] = 1'b0;
                    end
                end
                rsp_ready = ($urandom_range(2) != 0);
                #1;
                exp_rdy = '0;
                if (!outst) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (exp_rdy == '0 && req_valid[(ptr_m + k) % NUM_REQ])
                            exp_rdy[(ptr_m + k) % NUM_REQ] = 1'b1;
                    end
                end
                chk("rnd_ready", req_ready, exp_rdy);
                chk("rnd_busy", busy, outst);
                if (outst) begin
                    chk("rnd_rsp_valid", rsp_valid, (cyc - gcyc) >= LAT + 1);
                    chk("rnd_eng_din", eng_din, e_din);
                    if (rsp_valid) begin
                        chk("rnd_data", rsp_data, e_data);
                        chk("rnd_id", rsp_id, e_id);
                        chk("rnd_mode", rsp_mode, e_mode);
                        if (rsp_ready) begin
                            outst = 1'b0;
                            n_rsp++;
                        end
                    end
                end else begin
                    chk("rnd_idle_rsp", rsp_valid, 1'b0);
                end
                if (exp_rdy != '0) begin
                    g      = exp_rdy[1] ? 1 : 0;
                    outst  = 1'b1;
                    gcyc   = cyc;
                    e_din  = req_data[g*DATA_W +: DATA_W];
                    e_mode = req_mode[g];
                    e_id   = ID_W'(g);
                    e_data = e_mode ? (e_din ^ DEC_K) : (e_din ^ ENC_K);
                    ptr_m  = (g + 1) % NUM_REQ;
                    lastg  = g;
                end
            end
            chk("rnd_count", n_rsp, 30);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rc5_engine_sched.md
Name: rc5_engine_sched

Overview:
- Shares one RC5 encryption core and one RC5 decryption core (64-bit din/dout, fixed-latency, no handshake) among NUM_REQ requesters.
- Accepts one block at a time over a valid/ready handshake, using round-robin selection between requesters.
- Holds the engine input stable for the engine's fixed latency, then captures the selected core's output.
- Returns the result, tagged with the requester id, over a valid/ready response port.

Parameters:
- NUM_REQ, 2: number of requesters, must be 1 or more.
- DATA_W, 64: block width; matches the RC5 core's din/dout.
- LATENCY, 61: clock cycles from a stable engine input to a valid engine output; must be 1 or more.
- ID_W, max(1, clog2(NUM_REQ)): width of the requester tag.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: reset; asynchronous assertion, active-high.
- req_valid, input, NUM_REQ: per-requester request valid.
- req_ready, output, NUM_REQ: per-requester grant; one-hot or zero.
- req_data, input, NUM_REQ*DATA_W: requester i uses slice [i*DATA_W +: DATA_W].
- req_mode, input, NUM_REQ: per-requester mode; 0 = encrypt, 1 = decrypt.
- eng_din, output, DATA_W: registered input to both RC5 cores.
- eng_dout_enc, input, DATA_W: output of the encryption core.
- eng_dout_dec, input, DATA_W: output of the decryption core.
- rsp_valid, output, 1: response valid.
- rsp_ready, input, 1: response accepted.
- rsp_data, output, DATA_W: captured result.
- rsp_id, output, ID_W: index of the requester that owns rsp_data.
- rsp_mode, output, 1: mode of the operation that produced rsp_data.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset values: state = IDLE; eng_din = 0; rsp_valid = 0; rsp_data = 0; rsp_id = 0; rsp_mode = 0; round-robin pointer = 0; wait counter = 0.
- Reset outputs: req_ready = 0 while rst is high; busy = 0.
- Reset mid-operation: the in-flight block is discarded and no response is produced. A pending response is dropped.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - The arbiter picks the first requester with req_valid high, searching upward from the pointer with wrap-around.
  - req_ready = one-hot of the winner, combinational from req_valid and state. It is 0 when no requester is valid and 0 in WAIT and RESP.
  - On req_valid[g] & req_ready[g] at edge E0:
    - eng_din <= req_data[g]; the mode and id g are latched.
    - counter <= LATENCY-1; pointer <= (g+1) mod NUM_REQ; go to WAIT.
- WAIT:
  - eng_din is held constant.
  - If counter != 0, decrement it.
  - If counter == 0: rsp_data <= (latched mode ? eng_dout_dec : eng_dout_enc); rsp_id and rsp_mode take the latched values; rsp_valid <= 1; go to RESP.
  - The capture therefore happens at edge E0+LATENCY, and rsp_valid is first visible after that edge.
- RESP:
  - rsp_valid, rsp_data, rsp_id and rsp_mode are held stable until rsp_ready is high.
  - On rsp_ready at an edge: rsp_valid <= 0; go to IDLE. A new grant is possible on the following edge.
  - rsp_data, rsp_id and rsp_mode keep their last value after the handshake.
  - eng_din keeps its last value in IDLE and RESP.
- Throughput: at most one block per LATENCY+2 cycles when rsp_ready is held high.
- Requester data is sampled only at the grant edge. Later changes to req_data or req_mode have no effect.
- req_valid dropping while ungranted is legal and produces no grant.
- If NUM_REQ = 1, the arbiter degenerates to req_ready[0] = req_valid[0] & (state == IDLE).

Decomposition:
- Shared package rc5_sched_pkg:
  - state enumeration {IDLE, WAIT, RESP};
  - MODE_ENC = 1'b0, MODE_DEC = 1'b1;
  - function computing ID_W.
- One natural sub-module, rr_arbiter (parameter NUM_REQ):
  - inputs: req vector, pointer, enable;
  - outputs: one-hot grant and the encoded index.

Test Plan:
- Single encrypt, stub cores (enc = din ^ 64'hA5A5A5A5A5A5A5A5, dec = din ^ 64'h5A5A5A5A5A5A5A5A, each with LATENCY-cycle delay): requester 0 sends 64'h0123456789ABCDEF with mode 0 → rsp_valid appears exactly 61 cycles after the grant edge; rsp_data = 64'hA486E0C22C0E684A; rsp_id = 0; rsp_mode = 0.
- Contention: both requesters valid in the same cycle at reset pointer 0, with data 64'h1 and 64'h2 → requester 0 is served first, then requester 1; grant order 0,1,0,1 over four back-to-back pairs; ids match the data.
- Backpressure: rsp_ready held low for 20 cycles after rsp_valid → rsp_data, rsp_id and rsp_mode stay stable; no req_ready is asserted; busy = 1; on release the response is consumed once and IDLE is re-entered.
- Real cores, round trip: encrypt 64'h0123456789ABCDEF via requester 0, feed the result as a mode-1 request via requester 1 → the decrypt response equals 64'h0123456789ABCDEF.
- Reset mid-WAIT: rst pulsed 30 cycles after the grant → all outputs return to their reset values; no response follows; the next request completes normally.
- Mode select: the same input 64'hFFFF0000FFFF0000 is sent with mode 1 on stub cores → rsp_data = 64'hA5A55A5AA5A55A5A; rsp_mode = 1.
